// File: rtl/ub_pkg.sv
// Definitions shared between the unified buffer and its consumers:
// width derivations and the data-setup FSM state type.
package ub_pkg;

    function automatic int data_width(input int sa_length);
        return 8 * sa_length;
    endfunction

    function automatic int word_addr_width(input int addr_width, input int no_banks);
        return addr_width + $clog2(no_banks);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/skew_line.sv
// One lane's delay line: DEPTH registers carrying a byte and its valid bit,
// all advancing together under a shared enable.
module skew_line #(
    parameter int DEPTH = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sync_rst,
    input  logic       en,
    input  logic [7:0] din,
    input  logic       din_valid,
    output logic [7:0] dout,
    output logic       dout_valid
);

    generate
        if (DEPTH == 0) begin : g_pass
            // Lane 0 needs no extra delay; the control inputs are intentionally unused.
            logic unused_ctrl;
            assign unused_ctrl = ^{clk, rst, sync_rst, en};
            assign dout        = din;
            assign dout_valid  = din_valid;
        end else begin : g_delay
            logic [DEPTH-1:0][7:0] data_q, data_d;
            logic [DEPTH-1:0]      valid_q, valid_d;

            always_comb begin
                data_d     = data_q;
                valid_d    = valid_q;
                data_d[0]  = din;
                valid_d[0] = din_valid;
                for (int s = 1; s < DEPTH; s++) begin
                    data_d[s]  = data_q[s-1];
                    valid_d[s] = valid_q[s-1];
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_q  <= '0;
                    valid_q <= '0;
                end else if (sync_rst) begin
                    data_q  <= '0;
                    valid_q <= '0;
                end else if (en) begin
                    data_q  <= data_d;
                    valid_q <= valid_d;
                end
            end

            assign dout       = data_q[DEPTH-1];
            assign dout_valid = valid_q[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/systolic_data_setup.sv
// Streams a run of unified-buffer words into the systolic array edge,
// delaying byte lane i by i cycles so the array sees a diagonal wavefront.
module systolic_data_setup
    import ub_pkg::*;
#(
    parameter int SA_LENGTH  = 256,
    parameter int ADDR_WIDTH = 10,
    parameter int NO_BANKS   = 8,
    parameter int LEN_WIDTH  = 16,
    localparam int DATA_WIDTH      = data_width(SA_LENGTH),
    localparam int WORD_ADDR_WIDTH = word_addr_width(ADDR_WIDTH, NO_BANKS)
) (
    input  logic                       CLK,
    input  logic                       ASYNC_RST,
    input  logic                       SYNC_RST,
    input  logic                       EN,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic [WORD_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [LEN_WIDTH-1:0]       cmd_len,
    output logic                       ub_rden,
    output logic [WORD_ADDR_WIDTH-1:0] ub_rdaddr,
    input  logic [DATA_WIDTH-1:0]      ub_rddata,
    output logic [DATA_WIDTH-1:0]      sa_data,
    output logic [SA_LENGTH-1:0]       sa_valid,
    output logic                       busy,
    output logic                       done
);

    localparam int DRAIN_WIDTH = $clog2(SA_LENGTH + 2);

    state_t                     state_q, state_d;
    logic [LEN_WIDTH-1:0]       rem_q, rem_d;
    logic [WORD_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                       rden_q, rden_d;
    logic [DRAIN_WIDTH-1:0]     drain_q, drain_d;
    logic                       done_q, done_d;
    logic                       pend_q, pend_d;
    logic [DATA_WIDTH-1:0]      stage0_data_q, stage0_data_d;
    logic                       stage0_valid_q, stage0_valid_d;

    always_comb begin
        state_d        = state_q;
        rem_d          = rem_q;
        addr_d         = addr_q;
        rden_d         = rden_q;
        drain_d        = drain_q;
        done_d         = 1'b0;
        // ub_rddata answers the request issued one enabled cycle earlier.
        pend_d         = rden_q;
        stage0_valid_d = pend_q;
        stage0_data_d  = pend_q ? ub_rddata : '0;

        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    addr_d = cmd_addr;
                    rem_d  = cmd_len;
                    if (cmd_len != '0) begin
                        state_d = READ;
                        rden_d  = 1'b1;
                    end else begin
                        state_d = DRAIN;
                        drain_d = DRAIN_WIDTH'(1);
                    end
                end
            end
            READ: begin
                if (rem_q <= LEN_WIDTH'(1)) begin
                    state_d = DRAIN;
                    rden_d  = 1'b0;
                    rem_d   = '0;
                    // The last word needs SA_LENGTH more cycles until its top lane exits.
                    drain_d = DRAIN_WIDTH'(SA_LENGTH);
                end else begin
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    addr_d = addr_q + WORD_ADDR_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (drain_q == DRAIN_WIDTH'(1)) begin
                    done_d  = 1'b1;
                    drain_d = '0;
                end else if (drain_q == '0) begin
                    state_d = IDLE;
                end else begin
                    drain_d = drain_q - DRAIN_WIDTH'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge ASYNC_RST) begin
        if (ASYNC_RST) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            addr_q         <= '0;
            rden_q         <= 1'b0;
            drain_q        <= '0;
            done_q         <= 1'b0;
            pend_q         <= 1'b0;
            stage0_data_q  <= '0;
            stage0_valid_q <= 1'b0;
        end else if (SYNC_RST) begin
            state_q        <= IDLE;
            rem_q          <= '0;
            addr_q         <= '0;
            rden_q         <= 1'b0;
            drain_q        <= '0;
            done_q         <= 1'b0;
            pend_q         <= 1'b0;
            stage0_data_q  <= '0;
            stage0_valid_q <= 1'b0;
        end else if (EN) begin
            state_q        <= state_d;
            rem_q          <= rem_d;
            addr_q         <= addr_d;
            rden_q         <= rden_d;
            drain_q        <= drain_d;
            done_q         <= done_d;
            pend_q         <= pend_d;
            stage0_data_q  <= stage0_data_d;
            stage0_valid_q <= stage0_valid_d;
        end
    end

    generate
        for (genvar i = 0; i < SA_LENGTH; i++) begin : g_lane
            skew_line #(.DEPTH(i)) u_skew (
                .clk        (CLK),
                .rst        (ASYNC_RST),
                .sync_rst   (SYNC_RST),
                .en         (EN),
                .din        (stage0_data_q[i*8 +: 8]),
                .din_valid  (stage0_valid_q),
                .dout       (sa_data[i*8 +: 8]),
                .dout_valid (sa_valid[i])
            );
        end
    endgenerate

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign ub_rden   = rden_q;
    assign ub_rdaddr = addr_q;
    assign done      = done_q;

endmodule

// File: tb/tb_systolic_data_setup.sv
// Directed bench for systolic_data_setup with a 4-lane array and a buffer
// model whose byte i of word A reads back as (A+i) & 8'hFF.
module tb_systolic_data_setup;

    localparam int SA = 4;
    localparam int AW = 10;
    localparam int NB = 8;
    localparam int LW = 16;
    localparam int WA = 13;
    localparam int DW = 32;

    logic          CLK = 1'b0;
    logic          ASYNC_RST;
    logic          SYNC_RST;
    logic          EN;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [WA-1:0] cmd_addr;
    logic [LW-1:0] cmd_len;
    logic          ub_rden;
    logic [WA-1:0] ub_rdaddr;
    logic [DW-1:0] ub_rddata = '0;
    logic [DW-1:0] sa_data;
    logic [SA-1:0] sa_valid;
    logic          busy;
    logic          done;

    int errors = 0;
    int checks = 0;

    systolic_data_setup #(
        .SA_LENGTH  (SA),
        .ADDR_WIDTH (AW),
        .NO_BANKS   (NB),
        .LEN_WIDTH  (LW)
    ) dut (
        .CLK       (CLK),
        .ASYNC_RST (ASYNC_RST),
        .SYNC_RST  (SYNC_RST),
        .EN        (EN),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_addr  (cmd_addr),
        .cmd_len   (cmd_len),
        .ub_rden   (ub_rden),
        .ub_rdaddr (ub_rdaddr),
        .ub_rddata (ub_rddata),
        .sa_data   (sa_data),
        .sa_valid  (sa_valid),
        .busy      (busy),
        .done      (done)
    );

    always #5 CLK = ~CLK;

    // Buffer model, frozen by the same EN as the DUT.
    always @(posedge CLK) begin
        if (EN && ub_rden) begin
            for (int i = 0; i < SA; i++) ub_rddata[i*8 +: 8] <= 8'(int'(ub_rdaddr) + i);
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic stepClock();
        @(posedge CLK);
        #1;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, " cmd_ready"}, cmd_ready, 1);
        checkOutput({tag, " rden"}, ub_rden, 0);
        checkOutput({tag, " rdaddr"}, ub_rdaddr, 0);
        checkOutput({tag, " sa_data"}, sa_data, 0);
        checkOutput({tag, " sa_valid"}, sa_valid, 0);
        checkOutput({tag, " busy"}, busy, 0);
        checkOutput({tag, " done"}, done, 0);
    endtask

    // Issues one command and checks every cycle against the timing model, indexed by
    // enabled edges since the first request. abortAt >= 0 returns early at that index.
    task automatic applyStimulus(input int addr, input int len, input int dropStart,
                                 input int dropLen, input bit holdValid, input int abortAt);
        int j = 0;
        int cyc = 0;
        int doneIdx;
        int k;
        logic [DW-1:0] expData;
        logic [SA-1:0] expValid;
        string tag;
        doneIdx   = (len == 0) ? 1 : len + SA;
        cmd_addr  = WA'(addr);
        cmd_len   = LW'(len);
        cmd_valid = 1'b1;
        EN        = 1'b1;
        stepClock();
        if (!holdValid) cmd_valid = 1'b0;
        while (j <= doneIdx + 1) begin
            if (abortAt >= 0 && j == abortAt) return;
            tag = $sformatf("a%0d l%0d c%0d", addr, len, cyc);
            if (j == doneIdx + 1) begin
                checkOutput({tag, " ready"}, cmd_ready, 1);
                checkOutput({tag, " busy"}, busy, 0);
                checkOutput({tag, " rden"}, ub_rden, 0);
                checkOutput({tag, " done"}, done, 0);
                cmd_valid = 1'b0;
                break;
            end
            expData  = '0;
            expValid = '0;
            for (int i = 0; i < SA; i++) begin
                k = j - 2 - i;
                if (k >= 0 && k < len) begin
                    expValid[i]         = 1'b1;
                    expData[i*8 +: 8]   = 8'(((addr + k) % 8192) + i);
                end
            end
            checkOutput({tag, " rden"}, ub_rden, (j < len) ? 1 : 0);
            if (j < len) checkOutput({tag, " rdaddr"}, ub_rdaddr, (addr + j) % 8192);
            checkOutput({tag, " sa_valid"}, sa_valid, expValid);
            checkOutput({tag, " sa_data"}, sa_data, expData);
            checkOutput({tag, " done"}, done, (j == doneIdx) ? 1 : 0);
            checkOutput({tag, " busy"}, busy, 1);
            checkOutput({tag, " ready"}, cmd_ready, 0);
            EN = (cyc >= dropStart && cyc < dropStart + dropLen) ? 1'b0 : 1'b1;
            stepClock();
            if (EN) j++;
            cyc++;
        end
        cmd_valid = 1'b0;
        EN        = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        ASYNC_RST = 1'b0;
        SYNC_RST  = 1'b0;
        EN        = 1'b1;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_len   = '0;

        #12 ASYNC_RST = 1'b1;
        #1 checkIdle("rst-async");
        stepClock();
        stepClock();
        ASYNC_RST = 1'b0;
        stepClock();
        checkIdle("post-rst0");
        stepClock();
        checkIdle("post-rst1");

        applyStimulus(5, 3, -1, 0, 1'b0, -1);
        applyStimulus(8191, 2, -1, 0, 1'b0, -1);
        applyStimulus(300, 0, -1, 0, 1'b1, -1);
        stepClock();
        checkOutput("len0 no-reaccept busy", busy, 0);
        applyStimulus(0, 4, 2, 3, 1'b0, -1);

        // Synchronous reset must act even with EN low.
        applyStimulus(50, 3, -1, 0, 1'b0, 3);
        EN       = 1'b0;
        SYNC_RST = 1'b1;
        stepClock();
        SYNC_RST = 1'b0;
        EN       = 1'b1;
        checkIdle("sync-rst");

        applyStimulus(100, 2, -1, 0, 1'b0, 4);
        checkOutput("pre-rst lanes busy", sa_valid, 4'b0110);
        #2 ASYNC_RST = 1'b1;
        #1 checkIdle("rst-drain");
        stepClock();
        ASYNC_RST = 1'b0;
        for (int c = 0; c < 5; c++) begin
            stepClock();
            checkOutput($sformatf("after-rst c%0d done", c), done, 0);
            checkOutput($sformatf("after-rst c%0d valid", c), sa_valid, 0);
        end
        applyStimulus(20, 1, -1, 0, 1'b0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/systolic_data_setup.md
# systolic_data_setup

Downstream consumer of the unified buffer's word-read port; feeds the systolic array's input edge. On each command it streams a run of consecutive buffer words and applies the diagonal skew that a systolic array requires. Lane *i* (byte *i* of a word) reaches the array *i* cycles after lane 0. It owns the read-request side of the buffer's word port during a command and reports completion once the last skewed byte has left.

## Interface
- SA_LENGTH, 256: systolic array width in byte lanes; DataWidth = 8*SA_LENGTH.
- ADDR_WIDTH, 10: per-bank word address width, same as the buffer.
- NO_BANKS, 8: number of buffer banks; WordAddrWidth = ADDR_WIDTH + $clog2(NO_BANKS).
- LEN_WIDTH, 16: width of the command word count.

Ports:
- CLK  in  1  the single clock; all logic samples on the rising edge.
- ASYNC_RST  in  1  reset, asynchronous and active-high.
- SYNC_RST  in  1  synchronous reset, active-high. Same effect as ASYNC_RST. Acts regardless of EN.
- EN  in  1  global clock enable, shared with the buffer. When low, all state holds.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_addr  in  WordAddrWidth  first word address.
- cmd_len  in  LEN_WIDTH  number of words to stream.
- ub_rden  out  1  buffer word-read enable.
- ub_rdaddr  out  WordAddrWidth  buffer word-read address.
- ub_rddata  in  DataWidth  buffer read data, valid one enabled cycle after ub_rden.
- sa_data  out  DataWidth  skewed lane bytes. A lane that is not valid drives 0.
- sa_valid  out  SA_LENGTH  per-lane valid.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, READ, DRAIN.
- IDLE: cmd_ready=1. An accept (cmd_valid & cmd_ready & EN) latches the address and length.
  - If len≠0, go to READ.
  - If len=0, go to DRAIN with an empty pipe. done pulses on the next enabled cycle, then return to IDLE. No reads are issued.
- READ: ub_rden=1 for exactly len consecutive enabled cycles. ub_rdaddr runs cmd_addr, cmd_addr+1, …, modulo 2^WordAddrWidth, so it wraps to 0 with no error. After the last request, go to DRAIN.
- DRAIN: wait until the last word's lane SA_LENGTH-1 has been presented. done=1 in that same cycle. The next state is IDLE.
- Skew datapath:
  - ub_rddata is registered into lane stage 0.
  - Lane *i* passes through *i* further registers.
  - A valid bit travels alongside each lane.
- Commands never overlap; a new command is accepted only in IDLE.
- Reset (either kind), including mid-command:
  - FSM goes to IDLE and the command is abandoned with no done.
  - All skew registers and valids clear.
  - Reset values: cmd_ready=1; ub_rden=0; ub_rdaddr=0; sa_data=0; sa_valid=0; busy=0; done=0.
- EN low: the FSM, counters, address and skew registers all freeze. Outputs hold their values, including ub_rden. Because the buffer is frozen by the same EN, no word is skipped or duplicated.

## Timing
- ub_rden in cycle t gives ub_rddata in t+1. Lane 0 of that word appears on sa_data/sa_valid in t+2, and lane *i* in t+2+i.
- With the first request in cycle r0 and len=L, word *k* lane *i* appears in r0+2+k+i.
- done occurs in cycle r0+L+SA_LENGTH, assuming EN is held high.
- The first ub_rden is in the cycle after accept. The cycle after done is IDLE, with cmd_ready=1.
- All outputs are registered, with no combinational path from inputs to outputs. Exception: cmd_ready is decoded from state only.

## Structure
- Shared package ub_pkg holds:
  - The DataWidth and WordAddrWidth derivation functions, shared with the unified buffer.
  - The state enum typedef (IDLE, READ, DRAIN).
- Sub-module skew_line holds one lane's data and valid delay: parameter DEPTH, a byte plus valid bit, and an enable. Instantiate it SA_LENGTH times in a generate loop, with DEPTH=i.
- Counters in the top level:
  - Words-remaining counter: LEN_WIDTH bits.
  - Drain counter: $clog2(SA_LENGTH+2) bits.

## Test plan
Bench parameters: SA_LENGTH=4, ADDR_WIDTH=10, NO_BANKS=8. The buffer model returns byte *i* of word A as (A+i)&8'hFF.
- Reset: assert ASYNC_RST between edges → outputs are 0 immediately and cmd_ready=1; after deassert they stay idle with no ub_rden.
- Command addr=5, len=3 → ub_rdaddr is 5,6,7 in cycles r0..r0+2. Lane *i* of word *k* equals 5+k+i at r0+2+k+i. done pulses once, at r0+7. Then cmd_ready=1.
- Wrap: addr=8191, len=2 → ub_rdaddr is 8191 then 0. The sa_data lane 0 sequence is 8'hFF then 8'h00.
- Command len=0 → no ub_rden; done pulses in the cycle after the next enabled cycle after accept; cmd_valid held during DRAIN is not accepted.
- Drop EN for 3 cycles in the middle of READ (addr=0, len=4) → all outputs hold. On resume, addresses continue with no gap or duplicate, and done slips by exactly 3 cycles.
- Assert ASYNC_RST during DRAIN → no done, all valids clear. A following command addr=20, len=1 completes normally.
